// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and default widths for the instruction/data memory-port arbiter.
package arb_pkg;

   localparam int unsigned ADDR_W_DEF       = 32;
   localparam int unsigned DATA_W_DEF       = 32;
   localparam int unsigned MAX_D_STREAK_DEF = 4;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY_I,
      ARB_BUSY_D
   } arb_state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_t;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Unified memory port: the arbiter is the master, the memory model the slave.
interface imem_dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_be;
   logic [DATA_W-1:0]     mem_rdata;
   logic                  mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/imem_dmem_arbiter_perf_counters.sv
// Grant and conflict event counters; built only when ARB_PERF_CNT_EN is defined.
module arb_perf_counters (
   input  logic        clock,
   input  logic        reset,
   input  logic        grant_i,
   input  logic        grant_d,
   input  logic        conflict,
   output logic [31:0] perf_if_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_conflict_cycles
);
   // Free-running event counters, wrapping modulo 2^32
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_if_grants       <= '0;
         perf_d_grants        <= '0;
         perf_conflict_cycles <= '0;
      end else begin
         if (grant_i)  perf_if_grants       <= perf_if_grants + 32'd1;
         if (grant_d)  perf_d_grants        <= perf_d_grants + 32'd1;
         if (conflict) perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
      end
   end
endmodule

// File: rtl/imem_dmem_arbiter.sv
// Fetch/data arbiter for the shared memory port. Data has priority, bounded by
// a streak guard so a waiting fetch is granted after MAX_D_STREAK data grants.
// Optional feature macro: ARB_PERF_CNT_EN (adds grant/conflict counters).
module imem_dmem_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_flush,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   output logic                if_stall,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_valid,
   output logic                d_stall,
   imem_dmem_arbiter_if.master mem
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]         perf_if_grants,
   output logic [31:0]         perf_d_grants,
   output logic [31:0]         perf_conflict_cycles
`endif
);
   localparam int unsigned    SW         = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);

   arb_state_t          state, state_nxt;
   logic [SW-1:0]       streak;
   logic                squash;
   logic                grant_valid;
   owner_t              grant_owner;
   logic                d_wins;

   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] be_q;

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= ARB_IDLE;
      else       state <= state_nxt;
   end

   // Next-state: grant from IDLE, return to IDLE on the ack cycle
   always_comb begin
      state_nxt = state;
      unique case (state)
         ARB_IDLE: begin
            if (grant_valid) state_nxt = (grant_owner == OWN_D) ? ARB_BUSY_D : ARB_BUSY_I;
         end
         ARB_BUSY_I, ARB_BUSY_D: begin
            if (mem.mem_ack) state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Outputs: grant decision, responses and stalls
   always_comb begin
      d_wins      = d_req && (!if_req || (streak < STREAK_MAX));
      grant_valid = (state == ARB_IDLE) && (d_wins || if_req);
      grant_owner = d_wins ? OWN_D : OWN_I;
      // A flush arriving in the ack cycle itself drops the response as well
      if_valid    = mem.mem_ack && (state == ARB_BUSY_I) && !squash && !if_flush;
      d_valid     = mem.mem_ack && (state == ARB_BUSY_D);
      if_stall    = if_req && !if_valid;
      d_stall     = d_req && !d_valid;
      if_rdata    = mem.mem_rdata;
      d_rdata     = mem.mem_rdata;
   end

   assign mem.mem_req   = (state != ARB_IDLE);
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_be    = be_q;

   // Latch the winner's request fields at grant; they hold until the next grant
   always_ff @(posedge clock) begin
      if (reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (grant_valid) begin
         if (grant_owner == OWN_D) begin
            we_q    <= d_we;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            be_q    <= d_be;
         end else begin
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            wdata_q <= '0;
            be_q    <= '1;
         end
      end
   end

   // Streak of data grants taken while fetch was waiting
   always_ff @(posedge clock) begin
      if (reset) begin
         streak <= '0;
      end else if (grant_valid) begin
         if (grant_owner == OWN_D && if_req)
            streak <= (streak == STREAK_MAX) ? STREAK_MAX : streak + SW'(1);
         else
            streak <= '0;
      end
   end

   // Squash flag: remembers a flush seen during an outstanding fetch
   always_ff @(posedge clock) begin
      if (reset)
         squash <= 1'b0;
      else if (state == ARB_BUSY_I && !mem.mem_ack)
         squash <= squash | if_flush;
      else
         squash <= 1'b0;
   end

`ifdef ARB_PERF_CNT_EN
   logic conflict;
   assign conflict = (state == ARB_IDLE) && if_req && d_req;

   arb_perf_counters u_perf (
      .clock                (clock),
      .reset                (reset),
      .grant_i              (grant_valid && grant_owner == OWN_I),
      .grant_d              (grant_valid && grant_owner == OWN_D),
      .conflict             (conflict),
      .perf_if_grants       (perf_if_grants),
      .perf_d_grants        (perf_d_grants),
      .perf_conflict_cycles (perf_conflict_cycles)
   );
`else
   // Counters absent; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed, table-driven bench for imem_dmem_arbiter with hand sequences for
// the streak guard and (when ARB_PERF_CNT_EN is defined) the counters.
module tb_imem_dmem_arbiter;
   import arb_pkg::*;

   logic        clock;
   logic        reset;
   logic        if_req, if_flush, if_valid, if_stall;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_valid, d_stall;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_if_grants, perf_d_grants, perf_conflict_cycles;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   imem_dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

   imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
      .clock    (clock),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_flush (if_flush),
      .if_rdata (if_rdata),
      .if_valid (if_valid),
      .if_stall (if_stall),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_be     (d_be),
      .d_rdata  (d_rdata),
      .d_valid  (d_valid),
      .d_stall  (d_stall),
      .mem      (mem_bus)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_if_grants       (perf_if_grants),
      .perf_d_grants        (perf_d_grants),
      .perf_conflict_cycles (perf_conflict_cycles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic rst; logic ir; logic [31:0] ia; logic fl;
      logic dr; logic we; logic [31:0] da; logic [31:0] wd; logic [3:0] be;
      logic ack; logic [31:0] rd;
      logic cf; logic e_req; logic e_we; logic [31:0] e_addr; logic [31:0] e_wd; logic [3:0] e_be;
      logic e_iv; logic e_is; logic e_dv; logic e_ds;
   } vec_t;

   vec_t vecs [26];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic ir, input logic [31:0] ia, input logic fl,
                        input logic dr, input logic we, input logic [31:0] da,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic ack, input logic [31:0] rd);
      reset = rst; if_req = ir; if_addr = ia; if_flush = fl;
      d_req = dr; d_we = we; d_addr = da; d_wdata = wd; d_be = be;
      mem_bus.mem_ack = ack; mem_bus.mem_rdata = rd;
   endtask

   initial begin
      logic [9:0]  exp_d;
      logic [9:0]  got_d;
      int unsigned ngr;

      //            rst   ir    ia      fl    dr    we    da       wd            be     ack   rd              cf    req   we    addr     wd            be     iv    is    dv    ds
      vecs[0]  = '{1'b1,1'b0,32'h0 ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,32'h0        ,1'b1,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b0,1'b0,1'b0};
      vecs[1]  = '{1'b1,1'b1,32'h40,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,32'h0        ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b1,1'b0,1'b0};
      vecs[2]  = '{1'b0,1'b1,32'h40,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,32'h0        ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b1,1'b0,1'b0};
      vecs[3]  = '{1'b0,1'b1,32'h40,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,32'h0        ,1'b0,1'b1,1'b0,32'h40 ,32'h0        ,4'hF,1'b0,1'b1,1'b0,1'b0};
      vecs[4]  = '{1'b0,1'b1,32'h40,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,32'h0        ,1'b0,1'b1,1'b0,32'h40 ,32'h0        ,4'hF,1'b0,1'b1,1'b0,1'b0};
      vecs[5]  = '{1'b0,1'b1,32'h40,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b1,32'h12345678 ,1'b0,1'b1,1'b0,32'h40 ,32'h0        ,4'hF,1'b1,1'b0,1'b0,1'b0};
      vecs[6]  = '{1'b0,1'b0,32'h0 ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,32'h0        ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b0,1'b0,1'b0};
      vecs[7]  = '{1'b0,1'b1,32'h0 ,1'b0,1'b1,1'b1,32'h100,32'hDEADBEEF ,4'hF,1'b0,32'h0        ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b1,1'b0,1'b1};
      vecs[8]  = '{1'b0,1'b1,32'h0 ,1'b0,1'b1,1'b1,32'h100,32'hDEADBEEF ,4'hF,1'b0,32'h0        ,1'b0,1'b1,1'b1,32'h100,32'hDEADBEEF ,4'hF,1'b0,1'b1,1'b0,1'b1};
      vecs[9]  = '{1'b0,1'b1,32'h0 ,1'b0,1'b1,1'b1,32'h100,32'hDEADBEEF ,4'hF,1'b1,32'hCAFE0001 ,1'b0,1'b1,1'b1,32'h100,32'hDEADBEEF ,4'hF,1'b0,1'b1,1'b1,1'b0};
      vecs[10] = '{1'b0,1'b1,32'h0 ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,32'h0        ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b1,1'b0,1'b0};
      vecs[11] = '{1'b0,1'b1,32'h0 ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b1,32'h00000013 ,1'b0,1'b1,1'b0,32'h0  ,32'h0        ,4'hF,1'b1,1'b0,1'b0,1'b0};
      vecs[12] = '{1'b0,1'b0,32'h0 ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,32'h0        ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b0,1'b0,1'b0};
      vecs[13] = '{1'b0,1'b1,32'h20,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,32'h0        ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b1,1'b0,1'b0};
      vecs[14] = '{1'b0,1'b1,32'h20,1'b1,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,32'h0        ,1'b0,1'b1,1'b0,32'h20 ,32'h0        ,4'hF,1'b0,1'b1,1'b0,1'b0};
      vecs[15] = '{1'b0,1'b1,32'h80,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b1,32'hAAAA     ,1'b0,1'b1,1'b0,32'h20 ,32'h0        ,4'hF,1'b0,1'b1,1'b0,1'b0};
      vecs[16] = '{1'b0,1'b1,32'h80,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,32'h0        ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b1,1'b0,1'b0};
      vecs[17] = '{1'b0,1'b1,32'h80,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b1,32'h55       ,1'b0,1'b1,1'b0,32'h80 ,32'h0        ,4'hF,1'b1,1'b0,1'b0,1'b0};
      vecs[18] = '{1'b0,1'b0,32'h0 ,1'b0,1'b1,1'b0,32'h200,32'h0        ,4'h3,1'b0,32'h0        ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b0,1'b0,1'b1};
      vecs[19] = '{1'b0,1'b0,32'h0 ,1'b1,1'b1,1'b0,32'h200,32'h0        ,4'h3,1'b1,32'h77       ,1'b0,1'b1,1'b0,32'h200,32'h0        ,4'h3,1'b0,1'b0,1'b1,1'b0};
      vecs[20] = '{1'b0,1'b0,32'h0 ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b1,32'h99       ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b0,1'b0,1'b0};
      vecs[21] = '{1'b0,1'b0,32'h0 ,1'b0,1'b1,1'b1,32'h300,32'h11       ,4'hF,1'b0,32'h0        ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b0,1'b0,1'b1};
      vecs[22] = '{1'b0,1'b0,32'h0 ,1'b0,1'b1,1'b1,32'h300,32'h11       ,4'hF,1'b0,32'h0        ,1'b0,1'b1,1'b1,32'h300,32'h11       ,4'hF,1'b0,1'b0,1'b0,1'b1};
      vecs[23] = '{1'b1,1'b0,32'h0 ,1'b0,1'b1,1'b1,32'h300,32'h11       ,4'hF,1'b0,32'h0        ,1'b0,1'b1,1'b1,32'h300,32'h11       ,4'hF,1'b0,1'b0,1'b0,1'b1};
      vecs[24] = '{1'b0,1'b0,32'h0 ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b1,32'h5        ,1'b1,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b0,1'b0,1'b0};
      vecs[25] = '{1'b0,1'b0,32'h0 ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,32'h0        ,1'b0,1'b0,1'b0,32'h0  ,32'h0        ,4'h0,1'b0,1'b0,1'b0,1'b0};

      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      repeat (2) @(posedge clock);

      for (int i = 0; i < 26; i++) begin
         @(negedge clock);
         drive(vecs[i].rst, vecs[i].ir, vecs[i].ia, vecs[i].fl, vecs[i].dr, vecs[i].we,
               vecs[i].da, vecs[i].wd, vecs[i].be, vecs[i].ack, vecs[i].rd);
         #2;
         chk($sformatf("row%0d mem_req", i),  {31'd0, mem_bus.mem_req}, {31'd0, vecs[i].e_req});
         chk($sformatf("row%0d if_valid", i), {31'd0, if_valid},        {31'd0, vecs[i].e_iv});
         chk($sformatf("row%0d if_stall", i), {31'd0, if_stall},        {31'd0, vecs[i].e_is});
         chk($sformatf("row%0d d_valid", i),  {31'd0, d_valid},         {31'd0, vecs[i].e_dv});
         chk($sformatf("row%0d d_stall", i),  {31'd0, d_stall},         {31'd0, vecs[i].e_ds});
         if (vecs[i].e_req || vecs[i].cf) begin
            chk($sformatf("row%0d mem_we", i),   {31'd0, mem_bus.mem_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("row%0d mem_addr", i), mem_bus.mem_addr,        vecs[i].e_addr);
            chk($sformatf("row%0d mem_be", i),   {28'd0, mem_bus.mem_be}, {28'd0, vecs[i].e_be});
            if (vecs[i].e_we || vecs[i].cf)
               chk($sformatf("row%0d mem_wdata", i), mem_bus.mem_wdata, vecs[i].e_wd);
         end
         if (vecs[i].e_iv) chk($sformatf("row%0d if_rdata", i), if_rdata, vecs[i].rd);
         if (vecs[i].e_dv) chk($sformatf("row%0d d_rdata", i),  d_rdata,  vecs[i].rd);
      end

      // Streak guard: both sides always requesting, zero-wait memory.
      // Grant order must be D,D,D,D,I,D,D,D,D,I (bit i = 1 means data).
      exp_d = 10'b0111101111;
      got_d = '0;
      ngr   = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         drive(1'b0, 1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 32'h8, 32'h0, 4'hF, 1'b1, 32'h0);
         #2;
         if (mem_bus.mem_req) begin
            if (ngr < 10) got_d[ngr] = (mem_bus.mem_addr == 32'h8);
            ngr++;
         end
      end
      chk("streak grant count", ngr, 32'd10);
      for (int g = 0; g < 10; g++)
         chk($sformatf("streak grant%0d is_data", g), {31'd0, got_d[g]}, {31'd0, exp_d[g]});
      @(negedge clock);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

`ifdef ARB_PERF_CNT_EN
      begin
         logic [1:0] seq [11];
         // {if_req, d_req} per cycle, ack every cycle: one conflict, 3 fetches, 2 loads
         seq = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
         @(negedge clock);
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
         repeat (2) @(negedge clock);
         chk("perf reset if_grants", perf_if_grants, 32'd0);
         chk("perf reset d_grants", perf_d_grants, 32'd0);
         chk("perf reset conflicts", perf_conflict_cycles, 32'd0);
         for (int c = 0; c < 11; c++) begin
            drive(1'b0, seq[c][1], 32'h10, 1'b0, seq[c][0], 1'b0, 32'h20, 32'h0, 4'hF, 1'b1, 32'h0);
            @(negedge clock);
         end
         chk("perf if_grants", perf_if_grants, 32'd3);
         chk("perf d_grants", perf_d_grants, 32'd2);
         chk("perf conflicts", perf_conflict_cycles, 32'd1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (loads/stores) of the five-stage core. Grants one requester at a time, holds the granted request on the memory port until acknowledged, routes the response back, and generates the per-side stall lines the pipeline consumes. Data accesses have priority, with a bounded-streak guard so fetch cannot starve. Instantiated at top level between the pipeline stages and the memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, max consecutive data grants while fetch is waiting (≥1)
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, level, held until if_valid or if_flush
- if_addr  in  ADDR_W  fetch address (PC)
- if_flush  in  1  redirect (branch/JALR taken); squashes outstanding fetch response
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  fetch completes this cycle
- if_stall  out  1  fetch must hold PC
- d_req  in  1  data request, level, held until d_valid
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_rdata  out  DATA_W  load data, valid with d_valid
- d_valid  out  1  data access completes this cycle
- d_stall  out  1  memory stage must hold
- mem_req  out  1  request to memory, held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  memory completes the held request (any latency ≥0 cycles after mem_req rises)

## Operation
- FSM states ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D.
- IDLE: if d_req && (!if_req || streak < MAX_D_STREAK) → latch d fields, go BUSY_D; else if if_req → latch if_addr (mem_we=0, mem_be all ones), go BUSY_I; else stay.
- BUSY_x: mem_req=1 with latched fields; on mem_ack → IDLE. Fields never change while BUSY.
- Responses combinational: if_valid = mem_ack && BUSY_I && !squash && !if_flush; d_valid = mem_ack && BUSY_D; x_rdata = mem_rdata (don't-care otherwise).
- Stalls combinational: x_stall = x_req && !x_valid.
- Streak: on D grant, streak = if_req ? sat(streak+1, MAX_D_STREAK) : 0; on I grant, streak = 0.
- Squash: set when if_flush asserted in BUSY_I (memory transaction still completes, response dropped); cleared on return to IDLE. if_flush in IDLE or BUSY_D has no effect.
- mem_ack in IDLE ignored.

## Timing
- Reset values: state IDLE, mem_req 0, latched fields 0, streak 0, squash 0; if_valid/d_valid 0; stalls follow x_req.
- Grant at cycle N (IDLE) → mem_req high from N+1 → x_valid in the mem_ack cycle.
- Ack cycle always returns to IDLE; next grant earliest one cycle later (peak one access per 2 cycles with zero-wait memory).
- Simultaneous if_req and d_req in IDLE: D wins unless streak == MAX_D_STREAK, then I wins.
- Reset mid-transaction: state IDLE next cycle, mem_req drops; late mem_ack ignored.

## Configuration
- ARB_PERF_CNT_EN defined: adds outputs perf_if_grants, perf_d_grants, perf_conflict_cycles (32 bits each, reset 0, wrap modulo 2^32); conflict = IDLE cycle with both requests high.
- Undefined: ports and counters absent; arbitration identical.

## Structure
- Package arb_pkg: arb_state_t enum, owner enum (OWN_I, OWN_D), default widths.
- Sub-module arb_perf_counters, instantiated only under ARB_PERF_CNT_EN.

## Test plan
- Single fetch, if_addr=0x40, mem_ack 2 cycles after mem_req → mem_addr=0x40, mem_we=0, if_valid one cycle with if_rdata=mem_rdata, if_stall high until then.
- Both requests from reset, d_addr=0x100 store, if_addr=0x0 → data granted first (mem_we=1, mem_be=0xF), fetch granted next.
- if_req held, d_req continuously re-asserted, MAX_D_STREAK=4 → grants D,D,D,D,I,D,...
- if_flush during BUSY_I then mem_ack → no if_valid, if_stall stays high, new if_addr=0x80 fetched next.
- Reset while BUSY_D → mem_req 0 next cycle; stray mem_ack produces no d_valid.
- With ARB_PERF_CNT_EN: 3 fetches + 2 loads, one conflict → counters 3, 2, 1.
